// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   DEF_DIVIDEND_W / DEF_DIVISOR_W : default operand widths (8-bit / 4-bit)
//   DEF_CNT_W                      : bit-counter width for the default dividend
//   ST_*                           : FSM state encodings (IDLE, RUN, DONE)
package div_pkg;

  localparam int DEF_DIVIDEND_W = 8;
  localparam int DEF_DIVISOR_W  = 4;
  localparam int DEF_CNT_W      = $clog2(DEF_DIVIDEND_W);

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   partial      in   current partial remainder (DIVISOR_W+1 bits, always < divisor)
//   next_bit     in   next dividend bit, MSB-first
//   divisor      in   divisor
//   partial_next out  partial remainder after this step
//   q_bit        out  quotient bit produced by this step
module div_step #(
  parameter int DIVISOR_W = 4
) (
  input  logic [DIVISOR_W:0]   partial,
  input  logic                 next_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   partial_next,
  output logic                 q_bit
);

  // One bit wider than the stored partial so the shift never drops a bit,
  // even though the stored top bit is always 0 in practice.
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] divisor_ext;

  assign shifted     = {partial, next_bit};
  assign divisor_ext = {2'b00, divisor};
  assign q_bit       = (shifted >= divisor_ext);

  // When the subtract is skipped, the shifted value is kept as-is ("restore").
  assign partial_next = q_bit ? (DIVISOR_W+1)'(shifted - divisor_ext)
                              : (DIVISOR_W+1)'(shifted);

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-low reset
//   start     in   request; accepted only in IDLE
//   inta      in   dividend (DIVIDEND_W), sampled on the accepting edge
//   intb      in   divisor (DIVISOR_W), sampled on the accepting edge
//   busy      out  high while in RUN or DONE
//   done      out  one-cycle pulse; out/rem/div_zero valid from this cycle
//   out       out  quotient, held until the next result is loaded
//   rem       out  remainder, held until the next result is loaded
//   div_zero  out  divisor was zero, held with out/rem
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0;
// start while busy=1 is ignored. The result is announced by done=1 for
// exactly one cycle, after which busy drops and a new request may be taken
// on the following edge. DIVISOR_W must not exceed DIVIDEND_W.
module seq_divider
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] inta,
  input  logic [DIVISOR_W-1:0]  intb,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] out,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  div_zero
);

  localparam int CNT_W = ($clog2(DIVIDEND_W) < 1) ? 1 : $clog2(DIVIDEND_W);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [DIVISOR_W:0]    partial;
  logic [DIVISOR_W:0]    partial_next;
  logic [DIVIDEND_W-1:0] quot;
  logic [DIVIDEND_W-1:0] quot_next;
  logic                  q_bit;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_step (
    .partial     (partial),
    .next_bit    (dividend[DIVIDEND_W-1]),
    .divisor     (divisor),
    .partial_next(partial_next),
    .q_bit       (q_bit)
  );

  // Quotient bits enter at the LSB; after DIVIDEND_W steps the first bit
  // resolved has reached the MSB.
  assign quot_next = DIVIDEND_W'({quot, q_bit});

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      dividend <= '0;
      divisor  <= '0;
      partial  <= '0;
      quot     <= '0;
      out      <= '0;
      rem      <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            dividend <= inta;
            divisor  <= intb;
            partial  <= '0;
            quot     <= '0;
            cnt      <= CNT_W'(DIVIDEND_W - 1);
            if (intb == '0) begin
              // No iteration needed: publish the fixed divide-by-zero result.
              out      <= '1;
              rem      <= '0;
              div_zero <= 1'b1;
              state    <= ST_DONE;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          dividend <= dividend << 1;
          partial  <= partial_next;
          quot     <= quot_next;
          if (cnt == '0) begin
            out      <= quot_next;
            rem      <= partial_next[DIVISOR_W-1:0];
            div_zero <= 1'b0;
            state    <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] inta;
  logic [VW-1:0] intb;
  logic          busy;
  logic          done;
  logic [DW-1:0] out;
  logic [VW-1:0] rem;
  logic          div_zero;

  always #5 clk = ~clk;

  seq_divider dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .inta    (inta),
    .intb    (intb),
    .busy    (busy),
    .done    (done),
    .out     (out),
    .rem     (rem),
    .div_zero(div_zero)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  // Expected results as {div_zero, rem, out}, produced with plain / and %.
  logic [DW+VW:0] exp_q[$];
  logic           m_active    = 1'b0;
  logic           m_valid     = 1'b0;
  int             m_done_edge = 0;
  int             edge_n      = 0;
  logic [DW-1:0]  m_out       = '0;
  logic [VW-1:0]  m_rem       = '0;
  logic           m_dz        = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      edge_n++;
      if (rst !== 1'b1) begin
        m_active = 1'b0;
        m_out    = '0;
        m_rem    = '0;
        m_dz     = 1'b0;
        exp_q.delete();
      end else begin
        if (m_active && edge_n == m_done_edge + 1) begin
          m_active = 1'b0;
        end else if (!m_active && start) begin
          m_active = 1'b1;
          if (intb == '0) begin
            m_done_edge = edge_n;
            exp_q.push_back({1'b1, {VW{1'b0}}, {DW{1'b1}}});
          end else begin
            m_done_edge = edge_n + DW;
            exp_q.push_back({1'b0, VW'(inta % intb), DW'(inta / intb)});
          end
        end
        if (m_active && edge_n == m_done_edge && exp_q.size() > 0)
          {m_dz, m_rem, m_out} = exp_q.pop_front();
      end
      m_valid = 1'b1;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    logic [DW+VW+2:0] got;
    logic [DW+VW+2:0] exp;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        got = {busy, done, div_zero, rem, out};
        exp = {m_active, (m_active && edge_n == m_done_edge), m_dz, m_rem, m_out};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL cycle_model @edge %0d: got busy=%b done=%b dz=%b rem=%0d out=%0d expected busy=%b done=%b dz=%b rem=%0d out=%0d",
                   edge_n, busy, done, div_zero, rem, out,
                   exp[DW+VW+2], exp[DW+VW+1], exp[DW+VW], exp[DW+VW-1:DW], exp[DW-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Pulse start for one edge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
    @(negedge clk);
    inta  = a;
    intb  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the number of negedges advanced before done was seen, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles");
    end
  endtask

  task automatic run_check(input string name, input logic [DW-1:0] a, input logic [VW-1:0] b,
                           input int eq, input int er, input int edz, input int elat);
    int lat;
    start_op(a, b);
    wait_done(lat);
    check({name, "_latency"}, lat, elat);
    check({name, "_out"}, int'(out), eq);
    check({name, "_rem"}, int'(rem), er);
    check({name, "_dz"}, int'(div_zero), edz);
  endtask

  // ---------------- directed vectors ----------------
  int bnd_a[4] = '{255, 13, 255, 0};
  int bnd_b[4] = '{15, 14, 1, 9};
  int bnd_q[4] = '{17, 0, 255, 0};
  int bnd_r[4] = '{0, 13, 0, 0};

  initial begin
    int lat;
    int seen;
    rst   = 1'b0;
    start = 1'b0;
    inta  = '0;
    intb  = '0;

    repeat (2) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_out", int'(out), 0);
    check("reset_rem", int'(rem), 0);
    check("reset_dz", int'(div_zero), 0);
    rst = 1'b1;

    // Main case and busy from the accepting edge.
    start_op(8'd200, 4'd7);
    check("busy_after_accept", int'(busy), 1);
    wait_done(lat);
    check("d200_7_latency", lat, 8);
    check("d200_7_out", int'(out), 28);
    check("d200_7_rem", int'(rem), 4);
    check("d200_7_dz", int'(div_zero), 0);

    for (int i = 0; i < 4; i++)
      run_check($sformatf("bnd%0d", i), DW'(bnd_a[i]), VW'(bnd_b[i]), bnd_q[i], bnd_r[i], 0, 8);

    // Divide by zero, then a normal op clears div_zero.
    run_check("d100_0", 8'd100, 4'd0, 255, 0, 1, 0);
    run_check("d100_3", 8'd100, 4'd3, 33, 1, 0, 8);

    // Start during RUN is ignored; held start is taken after the IDLE gap.
    start_op(8'd200, 4'd7);
    repeat (2) @(negedge clk);
    inta  = 8'd50;
    intb  = 4'd5;
    start = 1'b1;
    wait_done(lat);
    check("ignore_latency", lat, 6);
    check("ignore_out", int'(out), 28);
    check("ignore_rem", int'(rem), 4);
    @(negedge clk);
    wait_done(lat);
    start = 1'b0;
    check("held_latency", lat, 9);
    check("held_out", int'(out), 10);
    check("held_rem", int'(rem), 0);

    // Reset in the middle of RUN abandons the operation.
    start_op(8'd200, 4'd7);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_out", int'(out), 0);
    check("midrst_rem", int'(rem), 0);
    check("midrst_dz", int'(div_zero), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("midrst_no_done", seen, 0);
    run_check("d81_9", 8'd81, 4'd9, 9, 0, 0, 8);

    // Exhaustive operand sweep with the division identity.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(DW'(a), VW'(b));
        wait_done(lat);
        if (b != 0) begin
          checks++;
          if (int'(out) * b + int'(rem) != a || int'(rem) >= b || div_zero !== 1'b0) begin
            errors++;
            $display("FAIL sweep %0d/%0d: got out=%0d rem=%0d dz=%b expected out*b+rem=a, rem<b, dz=0",
                     a, b, out, rem, div_zero);
          end
        end else begin
          checks++;
          if (div_zero !== 1'b1 || out !== 8'hFF || rem !== 4'd0) begin
            errors++;
            $display("FAIL sweep_zero %0d/0: got out=%0d rem=%0d dz=%b expected out=255 rem=0 dz=1",
                     a, out, rem, div_zero);
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
